// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: evaluates B/BL, redirects fetch, writes LR and flushes the pipeline.
module branch_redirect_ctrl #(
    parameter logic [31:0] PC_OFFSET    = 32'd8,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] LINK_OFFSET  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [3:0]  br_cond,
    input  logic        br_link,
    input  logic [23:0] br_imm24,
    input  logic [31:0] br_pc,
    input  logic [3:0]  flags_nzcv,
    output logic        redir_valid,
    input  logic        redir_ready,
    output logic [31:0] redir_target,
    output logic        lr_we,
    output logic [31:0] lr_data,
    output logic        flush,
    output logic        not_taken
);
    typedef enum logic [2:0] {IDLE, EVAL, REDIRECT, LINK, FLUSH} state_t;
    state_t state, state_nx;
    logic [3:0] cond_q, flags_q, cnt, cnt_nx;
    logic [23:0] imm_q;
    logic [31:0] pc_q;
    logic link_q, taken, not_taken_nx, n, z, c, v;
    assign {n, z, c, v} = flags_q;
    always_comb begin
        taken = 1'b0;
        case (cond_q)
            4'h0: taken = z;
            4'h1: taken = !z;
            4'h2: taken = c;
            4'h3: taken = !c;
            4'h4: taken = n;
            4'h5: taken = !n;
            4'h6: taken = v;
            4'h7: taken = !v;
            4'h8: taken = c && !z;
            4'h9: taken = !c || z;
            4'hA: taken = n == v;
            4'hB: taken = n != v;
            4'hC: taken = !z && (n == v);
            4'hD: taken = z || (n != v);
            4'hE: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        not_taken_nx = 1'b0;
        case (state)
            IDLE: if (br_valid && br_ready) state_nx = EVAL;
            EVAL: begin
                state_nx = taken ? REDIRECT : IDLE;
                not_taken_nx = !taken;
            end
            REDIRECT: if (redir_valid && redir_ready) state_nx = link_q ? LINK : FLUSH;
            LINK: state_nx = FLUSH;
            FLUSH: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (state_nx == FLUSH && state != FLUSH) cnt_nx = 4'(FLUSH_CYCLES);
    end
    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= 4'd0;
            br_ready <= 1'b0;
            redir_valid <= 1'b0;
            redir_target <= 32'd0;
            lr_we <= 1'b0;
            lr_data <= 32'd0;
            flush <= 1'b0;
            not_taken <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            br_ready <= state_nx == IDLE && !not_taken_nx;
            redir_valid <= state_nx == REDIRECT;
            lr_we <= state_nx == LINK;
            flush <= state_nx == FLUSH;
            not_taken <= not_taken_nx;
            if (state == EVAL && taken) redir_target <= pc_q + PC_OFFSET + {{6{imm_q[23]}}, imm_q, 2'b00};
            if (state_nx == LINK) lr_data <= pc_q + LINK_OFFSET;
        end
    end
    always_ff @(posedge clk) begin
        if (state == IDLE && br_valid && br_ready) begin
            cond_q <= br_cond;
            link_q <= br_link;
            imm_q <= br_imm24;
            pc_q <= br_pc;
            flags_q <= flags_nzcv;
        end
    end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed checks of branch redirect sequencing and timing.
module tb_branch_redirect_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic br_valid = 1'b0, br_ready, br_link = 1'b0, redir_valid, redir_ready = 1'b1;
    logic [3:0] br_cond = 4'hE, flags_nzcv = 4'h0;
    logic [23:0] br_imm24 = 24'd0;
    logic [31:0] br_pc = 32'd0, redir_target, lr_data;
    logic lr_we, flush, not_taken;
    int checks = 0, failures = 0;

    branch_redirect_ctrl dut (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
        .br_link(br_link), .br_imm24(br_imm24), .br_pc(br_pc), .flags_nzcv(flags_nzcv),
        .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_target(redir_target),
        .lr_we(lr_we), .lr_data(lr_data), .flush(flush), .not_taken(not_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && !br_ready; i++) tick();
        if (!br_ready) chk("ready_timeout", 32'(br_ready), 32'd1);
    endtask

    // Leaves the bench one cycle after the acceptance edge.
    task automatic issue(input logic [3:0] c, input logic l, input logic [23:0] imm,
                         input logic [31:0] pc, input logic [3:0] f);
        wait_ready();
        br_cond = c; br_link = l; br_imm24 = imm; br_pc = pc; flags_nzcv = f; br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
    endtask

    typedef struct { logic [3:0] c; logic [3:0] f; logic t; } cond_vec_t;
    cond_vec_t cv[8] = '{
        '{4'hC, 4'b1001, 1'b1}, '{4'hF, 4'b0100, 1'b0}, '{4'h2, 4'b0010, 1'b1},
        '{4'h9, 4'b0010, 1'b0}, '{4'hB, 4'b1000, 1'b1}, '{4'hD, 4'b0000, 1'b0},
        '{4'h6, 4'b0001, 1'b1}, '{4'h1, 4'b0100, 1'b0}
    };

    initial begin
        tick(); tick();
        chk("rst_br_ready", 32'(br_ready), 0);
        chk("rst_redir_valid", 32'(redir_valid), 0);
        chk("rst_target", redir_target, 0);
        chk("rst_lr_we", 32'(lr_we), 0);
        chk("rst_lr_data", lr_data, 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_not_taken", 32'(not_taken), 0);
        rst = 1'b0;
        tick();
        chk("idle_br_ready", 32'(br_ready), 1);

        // Forward B, AL
        issue(4'hE, 1'b0, 24'h000010, 32'h100, 4'h0);
        chk("fwd_c1_redir", 32'(redir_valid), 0);
        chk("fwd_c1_ready", 32'(br_ready), 0);
        tick();
        chk("fwd_c2_redir", 32'(redir_valid), 1);
        chk("fwd_c2_target", redir_target, 32'h148);
        tick();
        chk("fwd_c3_flush", 32'(flush), 1);
        chk("fwd_c3_redir", 32'(redir_valid), 0);
        chk("fwd_c3_lr_we", 32'(lr_we), 0);
        tick();
        chk("fwd_c4_flush", 32'(flush), 1);
        chk("fwd_c4_ready", 32'(br_ready), 0);
        tick();
        chk("fwd_c5_flush", 32'(flush), 0);
        chk("fwd_c5_ready", 32'(br_ready), 1);
        chk("fwd_target_hold", redir_target, 32'h148);

        // Backward and extreme negative offsets
        issue(4'hE, 1'b0, 24'hFFFFFE, 32'h200, 4'h0);
        tick();
        chk("back_target", redir_target, 32'h200);
        issue(4'hE, 1'b0, 24'h800000, 32'h02000000, 4'h0);
        tick();
        chk("neg_max_target", redir_target, 32'h8);

        // Address wrap, then BL from the same pc
        issue(4'hE, 1'b0, 24'h000001, 32'hFFFFFFF8, 4'h0);
        tick();
        chk("wrap_target", redir_target, 32'h4);
        issue(4'hE, 1'b1, 24'h000001, 32'hFFFFFFF8, 4'h0);
        tick();
        chk("bl_c2_redir", 32'(redir_valid), 1);
        tick();
        chk("bl_c3_lr_we", 32'(lr_we), 1);
        chk("bl_c3_lr_data", lr_data, 32'hFFFFFFFC);
        chk("bl_c3_flush", 32'(flush), 0);
        tick();
        chk("bl_c4_lr_we", 32'(lr_we), 0);
        chk("bl_c4_flush", 32'(flush), 1);
        tick();
        chk("bl_c5_flush", 32'(flush), 1);
        tick();
        chk("bl_c6_ready", 32'(br_ready), 1);
        chk("bl_lr_hold", lr_data, 32'hFFFFFFFC);

        // EQ with Z=0: not taken
        issue(4'h0, 1'b0, 24'h000010, 32'h300, 4'b0000);
        tick();
        chk("eq_c2_not_taken", 32'(not_taken), 1);
        chk("eq_c2_redir", 32'(redir_valid), 0);
        chk("eq_c2_ready", 32'(br_ready), 0);
        tick();
        chk("eq_c3_not_taken", 32'(not_taken), 0);
        chk("eq_c3_ready", 32'(br_ready), 1);
        chk("eq_c3_flush", 32'(flush), 0);
        chk("eq_target_hold", redir_target, 32'h4);

        // Condition table
        foreach (cv[i]) begin
            issue(cv[i].c, 1'b0, 24'd0, 32'h500, cv[i].f);
            tick();
            chk($sformatf("cond%0h_taken", cv[i].c), 32'(redir_valid), 32'(cv[i].t));
            chk($sformatf("cond%0h_nt", cv[i].c), 32'(not_taken), 32'(!cv[i].t));
        end

        // Backpressure on BL, with a second branch waiting
        redir_ready = 1'b0;
        issue(4'hE, 1'b1, 24'h000003, 32'h1000, 4'h0);
        tick();
        chk("bp_c2_redir", 32'(redir_valid), 1);
        chk("bp_c2_target", redir_target, 32'h1014);
        br_cond = 4'hE; br_link = 1'b0; br_imm24 = 24'd0; br_pc = 32'h2000; br_valid = 1'b1;
        for (int k = 3; k <= 5; k++) begin
            tick();
            chk($sformatf("bp_c%0d_redir", k), 32'(redir_valid), 1);
            chk($sformatf("bp_c%0d_target", k), redir_target, 32'h1014);
            chk($sformatf("bp_c%0d_ready", k), 32'(br_ready), 0);
            chk($sformatf("bp_c%0d_lr_we", k), 32'(lr_we), 0);
        end
        redir_ready = 1'b1;
        tick();
        chk("bp_link_lr_we", 32'(lr_we), 1);
        chk("bp_link_lr_data", lr_data, 32'h1004);
        chk("bp_link_redir", 32'(redir_valid), 0);
        tick();
        chk("bp_f1_lr_we", 32'(lr_we), 0);
        chk("bp_f1_flush", 32'(flush), 1);
        tick();
        chk("bp_f2_flush", 32'(flush), 1);
        chk("bp_f2_ready", 32'(br_ready), 0);
        tick();
        chk("bp_end_flush", 32'(flush), 0);
        chk("bp_end_ready", 32'(br_ready), 1);
        tick();
        br_valid = 1'b0;
        chk("bp_second_accepted", 32'(br_ready), 0);
        tick();
        chk("bp_second_target", redir_target, 32'h2008);
        wait_ready();

        // Reset during the first flush cycle
        issue(4'hE, 1'b0, 24'd0, 32'h300, 4'h0);
        tick();
        tick();
        chk("rf_c3_flush", 32'(flush), 1);
        rst = 1'b1;
        tick();
        chk("rf_flush", 32'(flush), 0);
        chk("rf_redir", 32'(redir_valid), 0);
        chk("rf_ready", 32'(br_ready), 0);
        rst = 1'b0;
        tick();
        chk("rf_idle_ready", 32'(br_ready), 1);
        issue(4'hE, 1'b0, 24'd0, 32'h40, 4'h0);
        tick();
        chk("rf_new_redir", 32'(redir_valid), 1);
        chk("rf_new_target", redir_target, 32'h48);
        wait_ready();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
